// File: rtl/kernel_bc_nbr_expand.sv
// Expands BC adjacency records (header + degree neighbour words) into per-edge records.
// Define KERNEL_BC_NBR_STATS_EN to add the stat_vtx / stat_edge counter ports.
module kernel_bc_nbr_expand #(
   parameter int DATA_WIDTH = 32,
   parameter int VID_W      = 20,
   parameter int DEG_W      = 12,
   parameter int OUT_W      = 1 + VID_W + DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_empty_n,
   output logic                  in_read,
   input  logic [DATA_WIDTH-1:0] in_dout,
   input  logic                  out_full_n,
   output logic                  out_write,
   output logic [OUT_W-1:0]      out_din,
`ifdef KERNEL_BC_NBR_STATS_EN
   output logic [31:0]           stat_vtx,
   output logic [31:0]           stat_edge,
`endif
   output logic                  idle
);

   typedef enum logic {ST_HDR, ST_NBR} state_t;

   state_t             state_q, state_d;
   logic [VID_W-1:0]   src_q, src_d;
   logic [DEG_W-1:0]   rem_q, rem_d;
   logic               out_vld_q, out_vld_d;
   logic [OUT_W-1:0]   out_din_q, out_din_d;
   logic               pop;
   logic               hdr_pop;

   always_comb begin
      in_read = 1'b0;
      if (!reset) begin
         if (state_q == ST_HDR) in_read = in_empty_n;
         else                   in_read = in_empty_n & (~out_vld_q | out_full_n);
      end
      pop     = in_read & in_empty_n;
      hdr_pop = pop & (state_q == ST_HDR);

      state_d   = state_q;
      src_d     = src_q;
      rem_d     = rem_q;
      // A pending record drains when accepted; a neighbour pop below refills it.
      out_vld_d = out_vld_q & ~out_full_n;
      out_din_d = out_din_q;

      if (pop) begin
         if (state_q == ST_HDR) begin
            src_d = in_dout[DATA_WIDTH-1:DEG_W];
            rem_d = in_dout[DEG_W-1:0];
            if (in_dout[DEG_W-1:0] != '0) state_d = ST_NBR;
         end else begin
            out_din_d = {(rem_q == DEG_W'(1)), src_q, in_dout};
            out_vld_d = 1'b1;
            rem_d     = rem_q - DEG_W'(1);
            if (rem_q == DEG_W'(1)) state_d = ST_HDR;
         end
      end
   end

`ifdef KERNEL_BC_NBR_STATS_EN
   logic [31:0] stat_vtx_q, stat_vtx_d;
   logic [31:0] stat_edge_q, stat_edge_d;

   always_comb begin
      stat_vtx_d  = stat_vtx_q + {31'd0, hdr_pop};
      stat_edge_d = stat_edge_q + {31'd0, out_vld_q & out_full_n};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stat_vtx_q  <= '0;
         stat_edge_q <= '0;
      end else begin
         stat_vtx_q  <= stat_vtx_d;
         stat_edge_q <= stat_edge_d;
      end
   end

   assign stat_vtx  = stat_vtx_q;
   assign stat_edge = stat_edge_q;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_HDR;
         src_q     <= '0;
         rem_q     <= '0;
         out_vld_q <= 1'b0;
         out_din_q <= '0;
      end else begin
         state_q   <= state_d;
         src_q     <= src_d;
         rem_q     <= rem_d;
         out_vld_q <= out_vld_d;
         out_din_q <= out_din_d;
      end
   end

   assign out_write = out_vld_q;
   assign out_din   = out_din_q;
   assign idle      = (state_q == ST_HDR) & ~out_vld_q;

endmodule

// File: tb/tb_kernel_bc_nbr_expand.sv
// Scoreboard bench for kernel_bc_nbr_expand: upstream FIFO modelled as a word queue,
// expected edge records queued at issue time and popped by an independent monitor.
module tb_kernel_bc_nbr_expand;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_empty_n;
   logic        in_read;
   logic [31:0] in_dout;
   logic        out_full_n;
   logic        out_write;
   logic [52:0] out_din;
   logic        idle;
`ifdef KERNEL_BC_NBR_STATS_EN
   logic [31:0] stat_vtx;
   logic [31:0] stat_edge;
`endif

   always #5 clk = ~clk;

   kernel_bc_nbr_expand #(.DATA_WIDTH(32), .VID_W(20), .DEG_W(12), .OUT_W(53)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_empty_n (in_empty_n),
      .in_read    (in_read),
      .in_dout    (in_dout),
      .out_full_n (out_full_n),
      .out_write  (out_write),
      .out_din    (out_din),
`ifdef KERNEL_BC_NBR_STATS_EN
      .stat_vtx   (stat_vtx),
      .stat_edge  (stat_edge),
`endif
      .idle       (idle)
   );

   int errors = 0;
   int checks = 0;
   int acc_cnt = 0;
   int acc_base = 0;
   int exp_vtx = 0;
   int full_mode = 0;   // 0: always space, 1: random, 2: forced full
   int empty_mode = 0;  // 0: data whenever queued, 1: toggle, 2: random
   bit tog = 1'b0;
   bit expect_no_read = 1'b0;
   logic [31:0] upq[$];
   logic [52:0] sbq[$];
   logic        prev_stall = 1'b0;
   logic [52:0] prev_din = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every accepted record must be the next one the model expects.
   always @(negedge clk) begin
      if (reset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_valid", 64'(out_write), 64'd1);
            check("hold_data", 64'(out_din), 64'(prev_din));
         end
         if (out_write && out_full_n) begin
            acc_cnt++;
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_record: got %h expected none", out_din);
            end else begin
               check("record", 64'(out_din), 64'(sbq.pop_front()));
            end
         end
         prev_stall = out_write && !out_full_n;
         prev_din   = out_din;
      end
   end

   task automatic refresh();
      tog = ~tog;
      in_empty_n = (upq.size() != 0) &&
                   (empty_mode == 0 || (empty_mode == 1 && tog) ||
                    (empty_mode == 2 && $urandom_range(0, 1) == 1));
      in_dout    = in_empty_n ? upq[0] : $urandom;
      out_full_n = (full_mode == 0) ? 1'b1 :
                   (full_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b0;
   endtask

   task automatic step();
      logic pop;
      @(negedge clk);
      pop = in_read & in_empty_n;
      if (expect_no_read) check("stall_in_read", 64'(in_read), 64'd0);
      @(posedge clk);
      #1;
      if (pop) begin
         check("pop_nonempty", 64'(upq.size() != 0), 64'd1);
         if (upq.size() != 0) void'(upq.pop_front());
      end
      refresh();
   endtask

   task automatic issue_vertex(input logic [19:0] vid, input int deg,
                               input logic [31:0] base, input bit rnd);
      logic [31:0] nbr;
      upq.push_back({vid, 12'(deg)});
      exp_vtx++;
      for (int i = 0; i < deg; i++) begin
         nbr = rnd ? $urandom : base + 32'(2 * i);
         upq.push_back(nbr);
         sbq.push_back({(i == deg - 1), vid, nbr});
      end
      refresh();
   endtask

   task automatic wait_drain(input int budget, input string name);
      int n = 0;
      while ((upq.size() != 0 || sbq.size() != 0 || out_write) && n < budget) begin
         step();
         n++;
      end
      check(name, 64'(n < budget), 64'd1);
   endtask

   task automatic check_stats(input string name);
`ifdef KERNEL_BC_NBR_STATS_EN
      check({name, "_vtx"}, 64'(stat_vtx), 64'(exp_vtx));
      check({name, "_edge"}, 64'(stat_edge), 64'(acc_cnt - acc_base));
`else
      check({name, "_idle"}, 64'(idle), 64'd1);
`endif
   endtask

   initial begin
      int a0;
      int n;
      reset      = 1'b1;
      in_empty_n = 1'b1;
      in_dout    = '1;
      out_full_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_read", 64'(in_read), 64'd0);
      check("rst_out_write", 64'(out_write), 64'd0);
      check("rst_out_din", 64'(out_din), 64'd0);
      check("rst_idle", 64'(idle), 64'd1);
      reset = 1'b0;
      refresh();

      // Header 0x00005003 with neighbours 7, 9, 11: one bubble then one record per cycle.
      issue_vertex(20'h00005, 3, 32'd7, 1'b0);
      a0 = acc_cnt;
      repeat (5) step();
      check("t1_throughput", 64'(acc_cnt - a0), 64'd3);
      wait_drain(20, "t1_drain");
      check("t1_idle", 64'(idle), 64'd1);

      // Zero-degree vertex followed by a degree-1 vertex.
      issue_vertex(20'h00001, 0, 32'd0, 1'b0);
      issue_vertex(20'h00002, 1, 32'h42, 1'b0);
      wait_drain(20, "t2_drain");
      check_stats("t2_stats");

      // Five cycles of downstream backpressure in the middle of a record.
      issue_vertex(20'h00006, 10, 32'd0, 1'b1);
      repeat (3) step();
      full_mode      = 2;
      out_full_n     = 1'b0;
      expect_no_read = 1'b1;
      repeat (5) step();
      expect_no_read = 1'b0;
      full_mode      = 0;
      refresh();
      wait_drain(40, "t3_drain");

      // Upstream data available every other cycle.
      empty_mode = 1;
      issue_vertex(20'h00007, 4, 32'd0, 1'b1);
      wait_drain(40, "t4_drain");
      empty_mode = 0;

      // Reset after two of four neighbours are accepted.
      issue_vertex(20'h00004, 4, 32'd0, 1'b1);
      a0 = acc_cnt;
      n  = 0;
      while (acc_cnt - a0 < 2 && n < 50) begin
         step();
         n++;
      end
      check("t5_two_accepted", 64'(acc_cnt - a0 >= 2), 64'd1);
      reset = 1'b1;
      upq.delete();
      sbq.delete();
      in_empty_n = 1'b1;
      in_dout    = $urandom;
      #1;
      check("t5_rst_in_read", 64'(in_read), 64'd0);
      step();
      check("t5_out_write", 64'(out_write), 64'd0);
      check("t5_idle", 64'(idle), 64'd1);
      reset    = 1'b0;
      exp_vtx  = 0;
      acc_base = acc_cnt;
      issue_vertex(20'h00003, 1, 32'd5, 1'b0);
      wait_drain(20, "t5_drain");

      // Maximum degree.
      a0 = acc_cnt;
      issue_vertex(20'hABCDE, 4095, 32'd0, 1'b1);
      wait_drain(6000, "t6_drain");
      check("t6_count", 64'(acc_cnt - a0), 64'd4095);
      check("t6_idle", 64'(idle), 64'd1);

      // Random traffic with random upstream gaps and downstream backpressure.
      full_mode  = 1;
      empty_mode = 2;
      for (int v = 0; v < 40; v++)
         issue_vertex(20'($urandom), $urandom_range(0, 6), 32'd0, 1'b1);
      wait_drain(3000, "t7_drain");
      full_mode  = 0;
      empty_mode = 0;
      refresh();
      step();
      check("final_idle", 64'(idle), 64'd1);
      check_stats("final_stats");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
